status_monitor: RTL and testbench
=================================

Name: status_monitor

Overview:
- Sits directly downstream of the core's status outputs (2-bit status code plus valid strobe); consumes one strobe per retired instruction.
- Buffers each strobe as a sequence-numbered record in a small FIFO, drained by the testbench/host through a valid/ready handshake.
- Keeps per-class retire counters, latches the terminating status (overflow or end), and signals completion once every record has been drained.

Parameters:
- FIFO_DEPTH, 8, record FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16, width of the sequence number and of each counter.
- WDT_CYCLES, 1024, idle-cycle limit for the watchdog (optional feature only).

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_status  input  2  status code: 00 R-type ok, 01 I-type ok, 10 overflow, 11 end.
- i_status_valid  input  1  single-cycle strobe; i_status is valid while this is high.
- o_rec_valid  output  1  FIFO head record available.
- o_rec_data  output  CNT_WIDTH+2  head record: {code[1:0], seq[CNT_WIDTH-1:0]}.
- i_rec_ready  input  1  consumer accepts the head record when o_rec_valid is also high.
- o_r_cnt  output  CNT_WIDTH  number of code 00 strobes accepted.
- o_i_cnt  output  CNT_WIDTH  number of code 01 strobes accepted.
- o_halt_code  output  2  terminating code (10 or 11); 00 until halted.
- o_halted  output  1  a terminating code has been accepted.
- o_done  output  1  halted or timed out, and FIFO empty.
- o_drop  output  1  sticky: a record was lost because the FIFO was full.
- o_timeout  output  1  watchdog fired.

Behaviour:
- Reset (async, i_rst=1): all outputs 0, FIFO empty, seq=0, state RUN. Reset mid-operation discards all records and restarts at seq 0.
- States:
  - RUN: accepts strobes.
  - DRAIN: halted, waiting for the FIFO to empty.
  - DONE: terminal.
  - TOUT: watchdog fired.
- Acceptance:
  - A strobe is accepted only in RUN; strobes in DRAIN, DONE or TOUT are ignored (no push, no count, no seq change).
  - Each accepted strobe increments seq by 1, wrapping modulo 2^CNT_WIDTH. The record carries the seq value before the increment, so the first record has seq 0.
  - Code 00 increments o_r_cnt; code 01 increments o_i_cnt. Both counters saturate at all-ones.
- Push:
  - An accepted strobe is written into the FIFO on that edge.
  - o_rec_valid rises on the next cycle (latency 1). The head is show-ahead: o_rec_data is stable while o_rec_valid=1 and i_rec_ready=0.
- Pop: on any edge where o_rec_valid=1 and i_rec_ready=1.
- Full FIFO:
  - Push with no pop: the record is dropped, o_drop is set (sticky until reset), and counters and seq still advance.
  - Push with a pop in the same cycle: both succeed and occupancy is unchanged.
- Empty FIFO: o_rec_valid=0; i_rec_ready is ignored.
- Halt:
  - An accepted code 10 or 11 is pushed like any other record.
  - On that edge, o_halt_code is latched, o_halted=1 and the state moves to DRAIN.
- DRAIN -> DONE: on the first edge where the FIFO is empty and no pop is occurring. The same edge sets o_done=1; o_done holds until reset.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.

Optional Feature:
- Macro: STATUS_MONITOR_WDT_EN.
- Enabled:
  - An idle counter clears on reset and on every accepted strobe, and increments each RUN cycle with no strobe.
  - When it reaches WDT_CYCLES-1 with no strobe that cycle: next state TOUT and o_timeout=1 (sticky).
  - In TOUT the FIFO continues to drain; o_done=1 once the FIFO is empty. o_halted stays 0.
- Disabled: no idle counter, TOUT unreachable, o_timeout tied 0.

Test Plan:
- Reset then strobes 00,01,00,11 on consecutive cycles with i_rec_ready=1 -> records {00,0},{01,1},{00,2},{11,3}; o_r_cnt=2, o_i_cnt=1, o_halt_code=11, o_done=1 after the last pop.
- i_rec_ready=0 and 10 strobes of 01 with FIFO_DEPTH=8 -> 8 records held, o_drop=1, o_i_cnt=10; draining gives seq 0..7.
- FIFO full, strobe and pop in the same cycle -> occupancy stays 8, o_drop stays 0, new record seq 8 at the tail.
- Strobe 10 followed by strobe 00 -> the second strobe is ignored, o_r_cnt unchanged, o_halt_code=10, state DRAIN until empty.
- Assert i_rst mid-stream with 3 records queued -> outputs 0 immediately; after release, the next strobe yields seq 0.
- STATUS_MONITOR_WDT_EN with WDT_CYCLES=16: one strobe then 16 idle cycles -> o_timeout=1; a later strobe is ignored; o_done=1 once drained.

Source files
------------

// File: rtl/status_monitor_if.sv
// Status strobe input and record drain handshake for status_monitor.
// slave: the monitor side; master: the core/host side.
interface status_monitor_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic [1:0]           i_status;
  logic                 i_status_valid;
  logic                 o_rec_valid;
  logic [CNT_WIDTH+1:0] o_rec_data;
  logic                 i_rec_ready;

  modport master (
    output i_status,
    output i_status_valid,
    output i_rec_ready,
    input  o_rec_valid,
    input  o_rec_data
  );

  modport slave (
    input  i_status,
    input  i_status_valid,
    input  i_rec_ready,
    output o_rec_valid,
    output o_rec_data
  );
endinterface

// File: rtl/status_monitor.sv
// Retire status monitor: seq-numbered record FIFO, per-class counters,
// halt latch and done. Optional watchdog: STATUS_MONITOR_WDT_EN.
// Ports: i_clk, i_rst (async high), bus (status in, record out),
// o_r_cnt/o_i_cnt, o_halt_code, o_halted, o_done, o_drop, o_timeout.
module status_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  status_monitor_if.slave      bus,
  output logic [CNT_WIDTH-1:0] o_r_cnt,
  output logic [CNT_WIDTH-1:0] o_i_cnt,
  output logic [1:0]           o_halt_code,
  output logic                 o_halted,
  output logic                 o_done,
  output logic                 o_drop,
  output logic                 o_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = CNT_WIDTH + 2;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN, DRAIN, DONE, TOUT
  } state_t;

  logic [DW-1:0] mem_q [FIFO_DEPTH];

  state_t state_q, state_d;
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [CNT_WIDTH-1:0] seq_q, seq_d;
  logic [CNT_WIDTH-1:0] r_cnt_q, r_cnt_d;
  logic [CNT_WIDTH-1:0] i_cnt_q, i_cnt_d;
  logic [1:0] halt_code_q, halt_code_d;
  logic halted_q, halted_d;
  logic done_q, done_d;
  logic drop_q, drop_d;

  logic empty, full, accept, pop, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign accept = bus.i_status_valid && (state_q == RUN);
  assign pop    = !empty && bus.i_rec_ready;
  // A full FIFO still takes the push when the head leaves this edge.
  assign push   = accept && (!full || pop);

`ifdef STATUS_MONITOR_WDT_EN
  localparam int IW = $clog2(WDT_CYCLES) + 1;
  localparam logic [IW-1:0] IDLE_LIM = IW'(WDT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_ONE = 1;
  logic [IW-1:0] idle_q, idle_d;
  logic timeout_q, timeout_d;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    seq_d       = seq_q;
    r_cnt_d     = r_cnt_q;
    i_cnt_d     = i_cnt_q;
    halt_code_d = halt_code_q;
    halted_d    = halted_q;
    done_d      = done_q;
    drop_d      = drop_q;
`ifdef STATUS_MONITOR_WDT_EN
    idle_d      = idle_q;
    timeout_d   = timeout_q;
`endif
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    if (accept) begin
      seq_d = seq_q + CNT_ONE;
      if (!push) drop_d = 1'b1;
      if (bus.i_status == 2'b00 && r_cnt_q != CNT_MAX)
        r_cnt_d = r_cnt_q + CNT_ONE;
      if (bus.i_status == 2'b01 && i_cnt_q != CNT_MAX)
        i_cnt_d = i_cnt_q + CNT_ONE;
    end
    unique case (state_q)
      RUN: begin
        if (accept && bus.i_status[1]) begin
          halt_code_d = bus.i_status;
          halted_d    = 1'b1;
          state_d     = DRAIN;
        end
`ifdef STATUS_MONITOR_WDT_EN
        if (accept) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LIM) begin
          state_d   = TOUT;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_ONE;
        end
`endif
      end
      DRAIN: begin
        if (empty) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      TOUT: begin
        if (empty) done_d = 1'b1;
      end
      DONE: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RUN;
      wr_q        <= '0;
      rd_q        <= '0;
      seq_q       <= '0;
      r_cnt_q     <= '0;
      i_cnt_q     <= '0;
      halt_code_q <= 2'b00;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
`ifdef STATUS_MONITOR_WDT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      seq_q       <= seq_d;
      r_cnt_q     <= r_cnt_d;
      i_cnt_q     <= i_cnt_d;
      halt_code_q <= halt_code_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
`ifdef STATUS_MONITOR_WDT_EN
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.i_status, seq_q};
  end

  assign bus.o_rec_valid = !empty;
  // Zero the head when empty so stale storage never shows on the bus.
  assign bus.o_rec_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign o_r_cnt     = r_cnt_q;
  assign o_i_cnt     = i_cnt_q;
  assign o_halt_code = halt_code_q;
  assign o_halted    = halted_q;
  assign o_done      = done_q;
  assign o_drop      = drop_q;
endmodule

// File: tb/tb_status_monitor.sv
// Directed self-checking bench for status_monitor.
// Default build; watchdog case runs when STATUS_MONITOR_WDT_EN is set.
module tb_status_monitor;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] r_cnt, i_cnt;
  logic [1:0] halt_code;
  logic halted, done, drop, timeout;
  int vecs = 0;
  int errs = 0;

  status_monitor_if #(.CNT_WIDTH(CW)) bus ();

  status_monitor #(
    .FIFO_DEPTH(8),
    .CNT_WIDTH(CW),
    .WDT_CYCLES(1024)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_r_cnt(r_cnt),
    .o_i_cnt(i_cnt),
    .o_halt_code(halt_code),
    .o_halted(halted),
    .o_done(done),
    .o_drop(drop),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] c);
    bus.i_status = c;
    bus.i_status_valid = 1'b1;
    tick();
    bus.i_status_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rec(input logic [1:0] c,
                                      input int s);
    logic [CW-1:0] sq;
    sq = CW'(s);
    return {14'd0, c, sq};
  endfunction

  initial begin
    bus.i_status = 2'b00;
    bus.i_status_valid = 1'b0;
    bus.i_rec_ready = 1'b0;
    #3;
    chk("rst_valid", bus.o_rec_valid, 0);
    chk("rst_data", bus.o_rec_data, 0);
    chk("rst_rcnt", r_cnt, 0);
    chk("rst_icnt", i_cnt, 0);
    chk("rst_flags", {halt_code, halted, done, drop, timeout}, 0);
    #4 rst = 1'b0;
    tick();

    // 00,01,00,11 with ready high: one pop per cycle behind the push
    bus.i_rec_ready = 1'b1;
    strobe(2'b00);
    chk("t1_head0", bus.o_rec_data, rec(2'b00, 0));
    strobe(2'b01);
    chk("t1_head1", bus.o_rec_data, rec(2'b01, 1));
    strobe(2'b00);
    chk("t1_head2", bus.o_rec_data, rec(2'b00, 2));
    strobe(2'b11);
    chk("t1_head3", bus.o_rec_data, rec(2'b11, 3));
    chk("t1_halted", {halt_code, halted}, {2'b11, 1'b1});
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_empty", bus.o_rec_valid, 0);
    chk("t1_done_wait", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_rcnt", r_cnt, 2);
    chk("t1_icnt", i_cnt, 1);

    // overflow: 10 strobes into 8 entries, ready low
    do_reset();
    bus.i_rec_ready = 1'b0;
    for (int k = 0; k < 10; k++) strobe(2'b01);
    chk("t2_drop", drop, 1);
    chk("t2_icnt", i_cnt, 10);
    chk("t2_hold", bus.o_rec_data, rec(2'b01, 0));
    bus.i_rec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain", bus.o_rec_data, rec(2'b01, k));
      tick();
    end
    chk("t2_empty", bus.o_rec_valid, 0);

    // full FIFO: push and pop on the same edge
    do_reset();
    bus.i_rec_ready = 1'b0;
    for (int k = 0; k < 8; k++) strobe(2'b01);
    chk("t3_nodrop_full", drop, 0);
    bus.i_rec_ready = 1'b1;
    strobe(2'b00);
    bus.i_rec_ready = 1'b0;
    chk("t3_nodrop", drop, 0);
    chk("t3_rcnt", r_cnt, 1);
    bus.i_rec_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk("t3_drain", bus.o_rec_data, rec(2'b01, k));
      tick();
    end
    chk("t3_tail", bus.o_rec_data, rec(2'b00, 8));
    tick();
    chk("t3_empty", bus.o_rec_valid, 0);

    // halt on 10, following 00 ignored
    do_reset();
    bus.i_rec_ready = 1'b1;
    strobe(2'b10);
    chk("t4_head", bus.o_rec_data, rec(2'b10, 0));
    strobe(2'b00);
    chk("t4_rcnt", r_cnt, 0);
    chk("t4_valid", bus.o_rec_valid, 0);
    chk("t4_halt", {halt_code, halted}, {2'b10, 1'b1});
    chk("t4_drain", done, 0);
    tick();
    chk("t4_done", done, 1);

    // async reset with 3 records queued
    do_reset();
    bus.i_rec_ready = 1'b0;
    for (int k = 0; k < 3; k++) strobe(2'b00);
    chk("t5_queued", r_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", bus.o_rec_valid, 0);
    chk("t5_rcnt", r_cnt, 0);
    #2 rst = 1'b0;
    tick();
    strobe(2'b01);
    chk("t5_seq0", bus.o_rec_data, rec(2'b01, 0));
    chk("t5_icnt", i_cnt, 1);
    chk("t5_rcnt_after", r_cnt, 0);

`ifdef STATUS_MONITOR_WDT_EN
    do_reset();
    bus.i_rec_ready = 1'b0;
    strobe(2'b00);
    for (int k = 0; k < 1023; k++) tick();
    chk("wdt_pre", timeout, 0);
    tick();
    chk("wdt_fire", timeout, 1);
    strobe(2'b01);
    chk("wdt_ignored", i_cnt, 0);
    chk("wdt_not_halted", halted, 0);
    chk("wdt_not_done", done, 0);
    bus.i_rec_ready = 1'b1;
    tick();
    tick();
    chk("wdt_done", done, 1);
`else
    chk("wdt_off", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
